// File: rtl/lm32_divider.sv
`default_nettype none
// ============================================================================
// Module   : lm32_divider
// Brief    : Iterative 32-step restoring divider for the LM32 execute stage.
//            Optional signed support via macro LM32_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lm32_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             divide_x,
    input  logic             modulus_x,
    input  logic             sign_x,
    input  logic             kill_x,
    input  logic [WIDTH-1:0] operand_0,
    input  logic [WIDTH-1:0] operand_1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             divide_by_zero
);

    localparam int         c_CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_DIVIDE = 1'b1;

    logic [0:0]         r_state,   w_state_nxt;
    logic [c_CNT_W-1:0] r_counter, w_counter_nxt;
    logic [WIDTH-1:0]   r_quot,    w_quot_nxt;
    logic [WIDTH-1:0]   r_rem,     w_rem_nxt;
    logic [WIDTH-1:0]   r_div,     w_div_nxt;
    logic               r_is_mod,  w_is_mod_nxt;
    logic [WIDTH-1:0]   r_result,  w_result_nxt;
    logic               r_done,    w_done_nxt;
    logic               r_dbz,     w_dbz_nxt;

    logic             w_start;
    logic [WIDTH-1:0] w_mag0, w_mag1;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_step, w_quot_step;
    logic [WIDTH-1:0] w_q_final, w_r_final;

    assign w_start     = (divide_x | modulus_x) & ~kill_x;
    assign w_shifted   = {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
    assign w_diff      = {1'b0, w_shifted} - {1'b0, r_div};
    assign w_rem_step  = w_diff[WIDTH] ? w_shifted : w_diff[WIDTH-1:0];
    assign w_quot_step = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

`ifdef LM32_DIVIDER_SIGNED_EN
    logic r_neg_q, w_neg_q_nxt;
    logic r_neg_r, w_neg_r_nxt;
    logic w_neg0, w_neg1;

    // Operands are iterated as magnitudes; signs are re-applied on the last step.
    assign w_neg0    = sign_x & operand_0[WIDTH-1];
    assign w_neg1    = sign_x & operand_1[WIDTH-1];
    assign w_mag0    = w_neg0 ? -operand_0 : operand_0;
    assign w_mag1    = w_neg1 ? -operand_1 : operand_1;
    assign w_q_final = r_neg_q ? -w_quot_step : w_quot_step;
    assign w_r_final = r_neg_r ? -w_rem_step  : w_rem_step;
`else
    logic w_unused_sign;

    assign w_unused_sign = sign_x;
    assign w_mag0        = operand_0;
    assign w_mag1        = operand_1;
    assign w_q_final     = w_quot_step;
    assign w_r_final     = w_rem_step;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_quot_nxt    = r_quot;
        w_rem_nxt     = r_rem;
        w_div_nxt     = r_div;
        w_is_mod_nxt  = r_is_mod;
        w_result_nxt  = r_result;
        w_done_nxt    = 1'b0;
        w_dbz_nxt     = 1'b0;
`ifdef LM32_DIVIDER_SIGNED_EN
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
`endif
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_div_nxt    = w_mag1;
                    w_is_mod_nxt = ~divide_x;
`ifdef LM32_DIVIDER_SIGNED_EN
                    w_neg_q_nxt  = w_neg0 ^ w_neg1;
                    w_neg_r_nxt  = w_neg0;
`endif
                    if (operand_1 == '0) begin
                        w_done_nxt   = 1'b1;
                        w_dbz_nxt    = 1'b1;
                        w_result_nxt = '0;
                    end else begin
                        w_state_nxt   = c_DIVIDE;
                        w_counter_nxt = c_CNT_W'(WIDTH - 1);
                        w_quot_nxt    = w_mag0;
                        w_rem_nxt     = '0;
                    end
                end
            end
            c_DIVIDE: begin
                if (kill_x) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_quot_nxt    = w_quot_step;
                    w_rem_nxt     = w_rem_step;
                    w_counter_nxt = r_counter - c_CNT_W'(1);
                    if (r_counter == '0) begin
                        w_result_nxt = r_is_mod ? w_r_final : w_q_final;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = c_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_IDLE;
            r_counter <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_is_mod  <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
`ifdef LM32_DIVIDER_SIGNED_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_quot    <= w_quot_nxt;
            r_rem     <= w_rem_nxt;
            r_div     <= w_div_nxt;
            r_is_mod  <= w_is_mod_nxt;
            r_result  <= w_result_nxt;
            r_done    <= w_done_nxt;
            r_dbz     <= w_dbz_nxt;
`ifdef LM32_DIVIDER_SIGNED_EN
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
`endif
        end
    end

    assign result         = r_result;
    assign busy           = (r_state == c_DIVIDE);
    assign done           = r_done;
    assign divide_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_lm32_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_lm32_divider
// Brief    : Directed self-checking bench for lm32_divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lm32_divider;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        divide_x = 1'b0;
    logic        modulus_x = 1'b0;
    logic        sign_x = 1'b0;
    logic        kill_x = 1'b0;
    logic [31:0] operand_0 = '0;
    logic [31:0] operand_1 = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        divide_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    int   lat;
    int   bcnt;
    logic dbz_seen;

    lm32_divider #(.WIDTH(32)) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .divide_x       (divide_x),
        .modulus_x      (modulus_x),
        .sign_x         (sign_x),
        .kill_x         (kill_x),
        .operand_0      (operand_0),
        .operand_1      (operand_1),
        .result         (result),
        .busy           (busy),
        .done           (done),
        .divide_by_zero (divide_by_zero)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, then watches up to 45 cycles; optional kill, second
    // request and reset injections happen at the given cycle index (0 = never).
    task automatic run_op(input logic dv, input logic md, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input int kill_at, input int req_at, input int rst_at,
                          output int o_lat, output int o_bcnt, output logic o_dbz);
        @(negedge clk_i);
        divide_x  = dv;
        modulus_x = md;
        sign_x    = sg;
        operand_0 = a;
        operand_1 = b;
        o_lat  = 0;
        o_bcnt = 0;
        o_dbz  = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk_i);
            divide_x  = 1'b0;
            modulus_x = 1'b0;
            kill_x    = 1'b0;
            rst_i     = 1'b0;
            if (k == kill_at) kill_x = 1'b1;
            if (k == req_at) begin
                modulus_x = 1'b1;
                operand_0 = 32'd50;
                operand_1 = 32'd7;
            end
            if (k == rst_at) rst_i = 1'b1;
            if (busy) o_bcnt++;
            if (done) begin
                o_lat = k;
                o_dbz = divide_by_zero;
                break;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset_result", result, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dbz", {31'd0, divide_by_zero}, 32'd0);

        run_op(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("div100_7_latency", 32'(lat), 32'd33);
        chk("div100_7_busy_cycles", 32'(bcnt), 32'd32);
        chk("div100_7_result", result, 32'd14);
        chk("div100_7_dbz", {31'd0, dbz_seen}, 32'd0);
        @(negedge clk_i);
        chk("done_pulse_cleared", {31'd0, done}, 32'd0);
        chk("result_held", result, 32'd14);

        run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("mod100_7_result", result, 32'd2);
        chk("mod100_7_latency", 32'(lat), 32'd33);

        run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("divmax_1_result", result, 32'hFFFF_FFFF);

        run_op(1'b1, 1'b0, 1'b0, 32'd5, 32'd9, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("div5_9_result", result, 32'd0);
        chk("div5_9_latency", 32'(lat), 32'd33);

        run_op(1'b1, 1'b0, 1'b0, 32'd1234, 32'd0, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("dbz_latency", 32'(lat), 32'd1);
        chk("dbz_flag", {31'd0, dbz_seen}, 32'd1);
        chk("dbz_busy_cycles", 32'(bcnt), 32'd0);
        chk("dbz_result", result, 32'd0);
        @(negedge clk_i);
        chk("dbz_pulse_cleared", {31'd0, divide_by_zero}, 32'd0);

        run_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd9, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("mod5_9_result", result, 32'd5);

        run_op(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3, 10, 0, 0, lat, bcnt, dbz_seen);
        chk("kill_no_done", 32'(lat), 32'd0);
        chk("kill_busy_cycles", 32'(bcnt), 32'd10);
        chk("kill_result_kept", result, 32'd5);
        chk("kill_busy_low", {31'd0, busy}, 32'd0);

        run_op(1'b1, 1'b0, 1'b0, 32'd9, 32'd3, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("div9_3_result", result, 32'd3);

        run_op(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3, 0, 5, 0, lat, bcnt, dbz_seen);
        chk("busy_req_latency", 32'(lat), 32'd33);
        chk("busy_req_result", result, 32'd333);

        run_op(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3, 0, 0, 20, lat, bcnt, dbz_seen);
        chk("rst_no_done", 32'(lat), 32'd0);
        chk("rst_busy_cycles", 32'(bcnt), 32'd20);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        run_op(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("post_rst_result", result, 32'd14);
        chk("post_rst_latency", 32'(lat), 32'd33);

        run_op(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("both_req_divide_wins", result, 32'd14);

`ifdef LM32_DIVIDER_SIGNED_EN
        run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("sdiv_m7_2", result, 32'hFFFF_FFFD);
        run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("smod_m7_2", result, 32'hFFFF_FFFF);
        run_op(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("sdiv_7_m2", result, 32'hFFFF_FFFD);
        run_op(1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("sdiv_overflow", result, 32'h8000_0000);
        chk("sdiv_overflow_latency", 32'(lat), 32'd33);
`else
        run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("sign_ignored_div", result, 32'h7FFF_FFFC);
        run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, lat, bcnt, dbz_seen);
        chk("sign_ignored_mod", result, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lm32_divider.md
Name: lm32_divider

Overview:
- Multi-cycle iterative divider: the inverse companion of the pipelined multiplier in the LM32 execute path.
- Accepts a divide or modulus request from the X stage and holds the pipeline via busy.
- Runs a 32-step restoring shift-subtract division, then returns a 32-bit quotient or remainder.
- Flags division by zero so the core can raise the divide-by-zero exception.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- divide_x  input  1  start request: quotient operation
- modulus_x  input  1  start request: remainder operation
- sign_x  input  1  signed operation (used only when LM32_DIVIDER_SIGNED_EN is defined)
- kill_x  input  1  abort: cancels the current or requested operation
- operand_0  input  WIDTH  dividend
- operand_1  input  WIDTH  divisor
- result  output  WIDTH  quotient or remainder, registered
- busy  output  1  operation in progress; the core stalls X while high
- done  output  1  one-cycle pulse: result is valid
- divide_by_zero  output  1  one-cycle pulse together with done when operand_1 was 0

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: result=0, busy=0, done=0, divide_by_zero=0, state=IDLE, counter=0, internal quotient/remainder/divisor registers=0.
- States: IDLE and DIVIDE.
- IDLE: a start is sampled at edge T0 when (divide_x|modulus_x)=1 and kill_x=0.
  - Operands, op type and sign info are latched.
  - If operand_1==0: stay IDLE. At T0, done=1, divide_by_zero=1, result=0 (visible for the one cycle after T0).
  - Otherwise: go to DIVIDE, busy=1, counter=WIDTH-1, quotient reg=dividend, remainder reg=0.
- DIVIDE step, once per edge:
  - shifted = {remainder[WIDTH-2:0], quotient[WIDTH-1]}.
  - diff = {1'b0,shifted} - {1'b0,divisor} (WIDTH+1 bits).
  - If diff[WIDTH]==0: remainder=diff[WIDTH-1:0] and new quotient LSB=1. Else remainder=shifted and new LSB=0.
  - quotient shifts left by one each step.
  - counter decrements each step.
- Last step (counter==0), at edge T32:
  - result = final quotient for divide, final remainder for modulus.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start at T0 -> result and done visible in the cycle after T32, i.e. 33 cycles from request. busy is high in the cycles after T0 through T31.
- done and divide_by_zero are pulses, cleared on the next edge. result holds its value until the next completion or reset.
- Boundary conditions:
  - divide_x and modulus_x both high: divide (quotient) wins.
  - Start request while busy: ignored; no queueing.
  - kill_x in IDLE with a start: no start; kill wins.
  - kill_x in DIVIDE: next edge -> IDLE, busy=0, no done, result unchanged.
  - Reset mid-operation: immediate return to reset values; no done.
  - Dividend < divisor: quotient 0, remainder = dividend.
  - Divisor=1: quotient = dividend, remainder 0.

Optional Feature:
- Macro LM32_DIVIDER_SIGNED_EN.
- Defined: when sign_x=1 at start, both operands are converted to magnitude (two's-complement negate if MSB set) before iteration. At the final step, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend. Negation is applied combinationally into the result register, so latency is unchanged.
  - Overflow case -2^31 / -1: quotient 0x80000000, remainder 0.
  - Divide-by-zero behaviour is unchanged.
- Not defined: sign_x is ignored and all operations are unsigned; the sign logic is not synthesized.

Test Plan:
- Unsigned divide 100/7 -> done pulse after 33 cycles, result=14, busy high for exactly 32 cycles. Modulus 100%7 -> result=2.
- Divide 0xFFFFFFFF/1 -> result 0xFFFFFFFF. Modulus 5%9 -> result 5. Divide 5/9 -> result 0.
- Divide 1234/0 -> next cycle done=1, divide_by_zero=1, result=0, busy never asserted.
- Start 1000/3; kill_x at cycle 10 -> busy drops next cycle, no done, result keeps prior value. Then start 9/3 -> result 3.
- Start while busy, and rst_i at cycle 20 of an operation -> second request ignored; reset clears all outputs and returns to IDLE, and a new request then completes normally.
- With LM32_DIVIDER_SIGNED_EN, sign_x=1:
  - -7/2 -> 0xFFFFFFFD (-3)
  - -7%2 -> 0xFFFFFFFF (-1)
  - 7/-2 -> -3
  - 0x80000000/0xFFFFFFFF -> 0x80000000
  - Without the macro, 0xFFFFFFF9/2 -> 0x7FFFFFFC.
